// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, word-align mask, PC increment.
// HALT exists only when FETCH_BOUNDS_CHECK_EN is defined.
package mips_fetch_pkg;

`ifdef FETCH_BOUNDS_CHECK_EN
    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1
    } fetch_state_e;
`endif

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_INCR         = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: redirect/stall inputs, ROM address/data pair and the decode-facing outputs.
// fetch_fault is present only when FETCH_BOUNDS_CHECK_EN is defined.
interface fetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        inst_valid;
`ifdef FETCH_BOUNDS_CHECK_EN
    logic        fetch_fault;
`endif

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_index, jr, jr_target, rom_data,
`ifdef FETCH_BOUNDS_CHECK_EN
        output fetch_fault,
`endif
        output rom_addr, inst_out, pc_out, pc_plus4, inst_valid
    );

    modport master (
        output stall, branch_taken, branch_target, jump, jump_index, jr, jr_target, rom_data,
`ifdef FETCH_BOUNDS_CHECK_EN
        input  fetch_fault,
`endif
        input  rom_addr, inst_out, pc_out, pc_plus4, inst_valid
    );

endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC priority mux: jr > jump > branch > sequential; zero latency.
module next_pc_sel
    import mips_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] next_pc_o
);

    always_comb begin
        next_pc_o = pc_plus4_i;
        if (jr_i) begin
            next_pc_o = word_align(jr_target_i);
        end else if (jump_i) begin
            next_pc_o = {pc_plus4_i[31:28], jump_index_i, 2'b00};
        end else if (branch_taken_i) begin
            next_pc_o = word_align(branch_target_i);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// PC register + fill FSM ahead of a registered ROM; redirects cost zero bubbles.
// Stall holds PC and re-reads the same ROM word; optional FETCH_BOUNDS_CHECK_EN adds HALT/fetch_fault.
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 10
) (
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.slave  bus
);

    if (RESET_PC[1:0] != 2'b00 || ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_param_chk
        $error("fetch_unit: RESET_PC must be word-aligned and ADDR_WIDTH in 1..29");
    end

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;

    assign pc_plus4 = pc_q + PC_INCR;

    next_pc_sel u_next_pc_sel (
        .pc_plus4_i      (pc_plus4),
        .jr_i            (bus.jr),
        .jr_target_i     (bus.jr_target),
        .jump_i          (bus.jump),
        .jump_index_i    (bus.jump_index),
        .branch_taken_i  (bus.branch_taken),
        .branch_target_i (bus.branch_target),
        .next_pc_o       (next_pc)
    );

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [32:0] ROM_BYTES = 33'd4 << ADDR_WIDTH;

    logic fault_q, fault_d;
    logic bad_target;

    // The misalignment test looks at the raw jr_target; next_pc has already had its low bits cleared.
    assign bad_target = ({1'b0, next_pc} >= ROM_BYTES) ||
                        (bus.jr && (bus.jr_target[1:0] != 2'b00));
    assign bus.fetch_fault = fault_q;
`endif

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        bus.rom_addr   = RESET_PC;
        bus.inst_valid = 1'b0;
        bus.inst_out   = 32'd0;
`ifdef FETCH_BOUNDS_CHECK_EN
        fault_d        = fault_q;
`endif
        case (state_q)
            FILL: begin
                state_d = RUN;
            end
            RUN: begin
                bus.inst_valid = 1'b1;
                bus.inst_out   = bus.rom_data;
                if (bus.stall) begin
                    bus.rom_addr = pc_q;
                end else begin
                    bus.rom_addr = next_pc;
                    pc_d         = next_pc;
`ifdef FETCH_BOUNDS_CHECK_EN
                    if (bad_target) begin
                        bus.rom_addr = pc_q;
                        pc_d         = pc_q;
                        state_d      = HALT;
                        fault_d      = 1'b1;
                    end
`endif
                end
            end
`ifdef FETCH_BOUNDS_CHECK_EN
            HALT: begin
                bus.rom_addr = pc_q;
            end
`endif
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= FILL;
            pc_q    <= RESET_PC;
`ifdef FETCH_BOUNDS_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef FETCH_BOUNDS_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign bus.pc_out   = pc_q;
    assign bus.pc_plus4 = pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered ROM model; word i holds 32'h1000_0000 + i*32'h101.
module tb_fetch_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fetch_unit_if fif ();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .ADDR_WIDTH (10)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM sharing the fetch reset; aliases modulo 4 KiB.
    always @(posedge clk) begin
        if (!rst_n) fif.rom_data <= 32'd0;
        else        fif.rom_data <= 32'h1000_0000 + 32'(fif.rom_addr[11:2]) * 32'h101;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        fif.stall         = 1'b0;
        fif.branch_taken  = 1'b0;
        fif.branch_target = 32'd0;
        fif.jump          = 1'b0;
        fif.jump_index    = 26'd0;
        fif.jr            = 1'b0;
        fif.jr_target     = 32'd0;
    endtask

    task automatic check_run(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        check_val({tag, "_valid"}, {31'd0, fif.inst_valid}, 32'd1);
        check_val({tag, "_pc"},    fif.pc_out,   pc);
        check_val({tag, "_p4"},    fif.pc_plus4, pc + 32'd4);
        check_val({tag, "_inst"},  fif.inst_out, inst);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        clear_inputs();

        // Reset state
        next_cycle();
        check_val("rst_valid", {31'd0, fif.inst_valid}, 32'd0);
        check_val("rst_pc",    fif.pc_out,   32'h0);
        check_val("rst_inst",  fif.inst_out, 32'h0);
        next_cycle();
        next_cycle();

        // FILL after release; a redirect here must be ignored
        rst_n         = 1'b1;
        fif.jr        = 1'b1;
        fif.jr_target = 32'h100;
        #1;
        check_val("fill_valid", {31'd0, fif.inst_valid}, 32'd0);
        check_val("fill_addr",  fif.rom_addr, 32'h0);
        check_val("fill_inst",  fif.inst_out, 32'h0);
        check_val("fill_p4",    fif.pc_plus4, 32'h4);

        // Sequential
        next_cycle();
        clear_inputs();
        #1;
        check_run("seq0", 32'h0, 32'h1000_0000);
        check_val("seq0_addr", fif.rom_addr, 32'h4);
        next_cycle();
        #1;
        check_run("seq1", 32'h4, 32'h1000_0101);
        check_val("seq1_addr", fif.rom_addr, 32'h8);

        // Stall with a branch pending: branch is dropped
        next_cycle();
        fif.stall         = 1'b1;
        fif.branch_taken  = 1'b1;
        fif.branch_target = 32'h80;
        #1;
        check_run("stall0", 32'h8, 32'h1000_0202);
        check_val("stall0_addr", fif.rom_addr, 32'h8);
        next_cycle();
        #1;
        check_run("stall1", 32'h8, 32'h1000_0202);
        next_cycle();
        clear_inputs();
        #1;
        check_run("stall2", 32'h8, 32'h1000_0202);
        check_val("stall2_addr", fif.rom_addr, 32'hC);
        next_cycle();
        #1;
        check_run("post_stall", 32'hC, 32'h1000_0303);

        // Priority: jr wins, low bits cleared
        next_cycle();
        fif.jr            = 1'b1;
        fif.jr_target     = 32'h43;
        fif.jump          = 1'b1;
        fif.jump_index    = 26'h40;
        fif.branch_taken  = 1'b1;
        fif.branch_target = 32'h80;
        #1;
        check_run("prio_src", 32'h10, 32'h1000_0404);
        check_val("prio_addr", fif.rom_addr, 32'h40);

        // Branch with unaligned target
        next_cycle();
        clear_inputs();
        fif.branch_taken  = 1'b1;
        fif.branch_target = 32'h26;
        #1;
        check_run("prio_dst", 32'h40, 32'h1000_1010);
        check_val("br_addr", fif.rom_addr, 32'h24);

        // Jump
        next_cycle();
        clear_inputs();
        fif.jump       = 1'b1;
        fif.jump_index = 26'h3;
        #1;
        check_run("br_dst", 32'h24, 32'h1000_0909);
        check_val("jmp_addr", fif.rom_addr, 32'hC);
        next_cycle();
        clear_inputs();
        #1;
        check_run("jmp_dst", 32'hC, 32'h1000_0303);

`ifndef FETCH_BOUNDS_CHECK_EN
        // PC wrap at top of address space; ROM aliases to word 0x3FF
        fif.branch_taken  = 1'b1;
        fif.branch_target = 32'hFFFF_FFFC;
        next_cycle();
        clear_inputs();
        #1;
        check_val("wrap_pc",   fif.pc_out,   32'hFFFF_FFFC);
        check_val("wrap_p4",   fif.pc_plus4, 32'h0);
        check_val("wrap_inst", fif.inst_out, 32'h1004_02FF);
        check_val("wrap_addr", fif.rom_addr, 32'h0);
        next_cycle();
        #1;
        check_run("wrap_dst", 32'h0, 32'h1000_0000);

        // Reset during a redirect
        rst_n         = 1'b0;
        fif.jr        = 1'b1;
        fif.jr_target = 32'h200;
        next_cycle();
        rst_n = 1'b1;
        clear_inputs();
        #1;
        check_val("mrst_valid", {31'd0, fif.inst_valid}, 32'd0);
        check_val("mrst_pc",    fif.pc_out, 32'h0);
        next_cycle();
        #1;
        check_run("mrst_run", 32'h0, 32'h1000_0000);
`else
        // Out-of-range branch halts
        fif.branch_taken  = 1'b1;
        fif.branch_target = 32'h1000;
        #1;
        check_val("oob_addr",  fif.rom_addr, 32'hC);
        check_val("oob_fault0", {31'd0, fif.fetch_fault}, 32'd0);
        next_cycle();
        clear_inputs();
        #1;
        check_val("halt_fault", {31'd0, fif.fetch_fault}, 32'd1);
        check_val("halt_valid", {31'd0, fif.inst_valid}, 32'd0);
        check_val("halt_inst",  fif.inst_out, 32'h0);
        check_val("halt_pc",    fif.pc_out,   32'hC);
        check_val("halt_addr",  fif.rom_addr, 32'hC);
        next_cycle();
        #1;
        check_val("halt_hold", fif.pc_out, 32'hC);

        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        #1;
        check_val("hrst_fault", {31'd0, fif.fetch_fault}, 32'd0);
        check_val("hrst_pc",    fif.pc_out, 32'h0);
        check_val("hrst_valid", {31'd0, fif.inst_valid}, 32'd0);
        next_cycle();
        #1;
        check_run("hrst_run", 32'h0, 32'h1000_0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- PC and fetch-sequencing stage that sits directly upstream of the synchronous instruction ROM in the single-cycle MIPS datapath.
- Holds the PC and computes next-PC (sequential, branch, jump, jr).
- Drives the ROM address so the registered ROM word always lines up with the PC register.
- Presents instruction, PC, PC+4 and a valid flag to decode.
- Absorbs the ROM's one-cycle read latency with a small fill state machine, so redirects cost zero bubbles.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- ADDR_WIDTH, 10: ROM word-address width; the ROM spans bytes 0 .. 4*2**ADDR_WIDTH-1.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- stall  in  1  hold PC and instruction this cycle.
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  32  byte address of the branch target.
- jump  in  1  J/JAL redirect.
- jump_index  in  26  instr_index field of J/JAL.
- jr  in  1  JR/JALR redirect.
- jr_target  in  32  register-sourced target.
- rom_addr  out  32  byte address to the ROM addr_in.
- rom_data  in  32  byte-corrected word from the ROM data_out.
- inst_out  out  32  instruction at pc_out; 0 when not valid.
- pc_out  out  32  PC of inst_out.
- pc_plus4  out  32  pc_out + 4, for link registers and branch offsets.
- inst_valid  out  1  inst_out is a real fetched instruction.

Behaviour:
- FSM states: FILL, RUN (plus HALT under the optional feature).
- Reset (reset==0 at posedge, from any state, including mid-stall or mid-redirect): pc <= RESET_PC, state <= FILL. The ROM is reset by the same source, inverted, so it outputs 0.
- FILL:
  - rom_addr = RESET_PC; inst_valid = 0; inst_out = 0.
  - stall and all redirects are ignored.
  - At the next posedge with reset==1: state <= RUN, pc stays RESET_PC.
  - The first valid instruction (rom[RESET_PC]) is therefore visible exactly 1 cycle after reset release.
- RUN:
  - inst_valid = 1; inst_out = rom_data, a combinational pass-through.
  - next_pc priority: jr > jump > branch_taken > sequential.
  - jr: next_pc = {jr_target[31:2], 2'b00}; low bits are silently cleared.
  - jump: next_pc = {pc_plus4[31:28], jump_index, 2'b00}.
  - branch: next_pc = {branch_target[31:2], 2'b00}.
  - sequential: next_pc = pc + 4, 32-bit with natural wrap at 32'hFFFF_FFFC -> 0.
  - rom_addr = stall ? pc : next_pc, combinational. The ROM registers the word at the same edge the PC updates, so redirect latency is 0 extra cycles: the target instruction appears on inst_out in the cycle immediately after the redirect cycle.
  - stall=1: pc holds; the ROM re-reads the same word; inst_out, pc_out and inst_valid are unchanged. Redirects asserted alongside stall are dropped; the upstream must re-assert them.
- Addresses beyond ROM size alias modulo 4*2**ADDR_WIDTH inside the ROM. The PC itself is not truncated.
- pc_plus4 is always pc_out + 4, including during FILL.

Optional Feature:
- Macro: FETCH_BOUNDS_CHECK_EN.
- When defined:
  - Adds output fetch_fault (1 bit) and a HALT state.
  - In RUN, if next_pc >= 4*2**ADDR_WIDTH, or a jr_target with jr active has bits [1:0] != 0, the redirect/advance is not taken. Instead: state <= HALT, pc holds, fetch_fault <= 1.
  - In HALT: inst_valid = 0, inst_out = 0, rom_addr = pc. Only reset exits HALT.
  - fetch_fault resets to 0.
- When undefined: no port, no HALT state; aliasing and bit-clearing as in Behaviour.

Decomposition:
- Shared package mips_fetch_pkg holds:
  - state encoding (FILL=2'd0, RUN=2'd1, HALT=2'd2);
  - the word-align mask;
  - the PC increment constant 32'd4.
- One natural sub-module, next_pc_sel: a combinational priority mux producing next_pc from pc, pc_plus4 and the redirect inputs.
- The FSM and PC register stay in fetch_unit.

Test Plan:
- Reset/fill: hold reset=0 for 3 cycles, release. Cycle 1: inst_valid=0, rom_addr=0. Cycle 2: inst_valid=1, pc_out=0, inst_out=rom word 0.
- Sequential: 4 RUN cycles, no redirects. pc_out = 0, 4, 8, 12; rom_addr leads by one word each cycle.
- Priority: at pc=0x10, assert jr (jr_target=0x43), jump (jump_index=0x40) and branch (target 0x80) together. Next cycle pc_out=0x40, inst_out=rom word 16.
- Jump: at pc=0x24, jump with jump_index=0x3. Next cycle pc_out=0x0000_000C.
- Stall: stall=1 for 2 cycles at pc=0x8 with branch_taken=1. pc_out stays 0x8 and inst_out is unchanged; after release pc_out=0xC.
- Reset mid-run with FETCH_BOUNDS_CHECK_EN:
  - branch to 0x1000 (ADDR_WIDTH=10) -> fetch_fault=1, inst_valid=0, pc held.
  - then reset=0 for 1 cycle -> FILL, fetch_fault=0, pc_out=RESET_PC.
